// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame controller.
package ws2812_pkg;

  localparam int unsigned PixelBitsGrb  = 24;
  localparam int unsigned PixelBitsGrbw = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSend,
    StWait,
    StLatch,
    StDone
  } state_e;

endpackage

// File: rtl/ws2812_ctrl.sv
// WS2812 frame sequencer: fetches pixels, serialises them MSB first to an external
// bit encoder, then holds the line low for the latch period.
module ws2812_ctrl
  import ws2812_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = PixelBitsGrb
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic [7:0]            pixel_cnt_in,
  input  logic [15:0]           latch_cnt_in,
  output logic                  pix_rd_out,
  output logic [7:0]            pix_addr_out,
  input  logic [PIXEL_BITS-1:0] pix_data_in,
  output logic                  bit_rdy_out,
  output logic                  bit_data_out,
  input  logic                  bit_done_in,
  output logic                  busy_out,
  output logic                  frame_done_out
);

  localparam int unsigned BitCntW = $clog2(PIXEL_BITS);

  state_e                state_q;
  logic [7:0]            pix_cnt_q;
  logic [7:0]            idx_q;
  logic [15:0]           latch_q;
  logic [PIXEL_BITS-1:0] shift_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic [8:0]            idx_next;

  assign idx_next = {1'b0, idx_q} + 9'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= StIdle;
      pix_cnt_q      <= '0;
      idx_q          <= '0;
      latch_q        <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      pix_rd_out     <= 1'b0;
      pix_addr_out   <= '0;
      bit_rdy_out    <= 1'b0;
      bit_data_out   <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      pix_rd_out     <= 1'b0;
      bit_rdy_out    <= 1'b0;
      frame_done_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start_in) begin
            pix_cnt_q    <= pixel_cnt_in;
            latch_q      <= latch_cnt_in;
            idx_q        <= '0;
            busy_out     <= 1'b1;
            bit_data_out <= 1'b0;
            if (pixel_cnt_in != 8'd0) begin
              state_q      <= StFetch;
              pix_rd_out   <= 1'b1;
              pix_addr_out <= '0;
            end else begin
              state_q <= StLatch;
            end
          end
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          shift_q      <= pix_data_in;
          bit_cnt_q    <= BitCntW'(PIXEL_BITS - 1);
          bit_data_out <= pix_data_in[PIXEL_BITS-1];
          bit_rdy_out  <= 1'b1;
          state_q      <= StSend;
        end
        StSend: state_q <= StWait;
        StWait: begin
          if (bit_done_in) begin
            shift_q <= shift_q << 1;
            if (bit_cnt_q != '0) begin
              bit_cnt_q    <= bit_cnt_q - 1'b1;
              bit_data_out <= shift_q[PIXEL_BITS-2];
              bit_rdy_out  <= 1'b1;
              state_q      <= StSend;
            end else if (idx_next < {1'b0, pix_cnt_q}) begin
              idx_q        <= idx_q + 8'd1;
              pix_addr_out <= idx_q + 8'd1;
              pix_rd_out   <= 1'b1;
              state_q      <= StFetch;
            end else begin
              bit_data_out <= 1'b0;
              state_q      <= StLatch;
            end
          end
        end
        StLatch: begin
          // A zero-length latch still passes through LATCH for one cycle.
          if (latch_q <= 16'd1) begin
            frame_done_out <= 1'b1;
            state_q        <= StDone;
          end else begin
            latch_q <= latch_q - 16'd1;
          end
        end
        StDone: begin
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Bench for ws2812_ctrl: 24- and 32-bit instances, pixel memory and bit-encoder models,
// a transaction monitor and a frame-level reference of the expected bit stream and timing.
module tb_ws2812_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  pixel_cnt = '0;
  logic [15:0] latch_cnt = '0;
  logic [31:0] pix_data = '0;
  logic        bit_done = 1'b0;
  logic        sel = 1'b0;

  logic       rd24, rdy24, bit24, busy24, fd24;
  logic [7:0] addr24;
  logic       rd32, rdy32, bit32, busy32, fd32;
  logic [7:0] addr32;

  always #5 clk = ~clk;

  ws2812_ctrl #(.PIXEL_BITS(24)) u_dut24 (
    .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start & ~sel),
    .pixel_cnt_in(pixel_cnt), .latch_cnt_in(latch_cnt),
    .pix_rd_out(rd24), .pix_addr_out(addr24), .pix_data_in(pix_data[23:0]),
    .bit_rdy_out(rdy24), .bit_data_out(bit24), .bit_done_in(bit_done & ~sel),
    .busy_out(busy24), .frame_done_out(fd24)
  );

  ws2812_ctrl #(.PIXEL_BITS(32)) u_dut32 (
    .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start & sel),
    .pixel_cnt_in(pixel_cnt), .latch_cnt_in(latch_cnt),
    .pix_rd_out(rd32), .pix_addr_out(addr32), .pix_data_in(pix_data),
    .bit_rdy_out(rdy32), .bit_data_out(bit32), .bit_done_in(bit_done & sel),
    .busy_out(busy32), .frame_done_out(fd32)
  );

  logic       s_rd, s_rdy, s_bit, s_busy, s_fd, s_bd;
  logic [7:0] s_addr;
  logic [12:0] o24, o32;
  assign s_rd   = sel ? rd32 : rd24;
  assign s_addr = sel ? addr32 : addr24;
  assign s_rdy  = sel ? rdy32 : rdy24;
  assign s_bit  = sel ? bit32 : bit24;
  assign s_busy = sel ? busy32 : busy24;
  assign s_fd   = sel ? fd32 : fd24;
  assign s_bd   = bit_done;
  assign o24 = {rd24, addr24, rdy24, bit24, busy24, fd24};
  assign o32 = {rd32, addr32, rdy32, bit32, busy32, fd32};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel buffer: data valid the cycle after the read strobe.
  logic [31:0] mem [256];
  always @(posedge clk) if (s_rd) pix_data <= mem[s_addr];

  // Bit encoder: done pulse enc_delay cycles after the rdy pulse; not reset on purpose.
  int enc_delay = 3;
  int enc_left = 0;
  always @(posedge clk) begin
    if (s_rdy) begin
      enc_left <= enc_delay - 1;
      bit_done <= (enc_delay == 1);
    end else if (enc_left > 0) begin
      enc_left <= enc_left - 1;
      bit_done <= (enc_left == 1);
    end else begin
      bit_done <= 1'b0;
    end
  end

  // Monitor
  logic [7:0] rd_q[$];
  int         rd_t[$];
  logic       bit_q[$];
  int         rdy_t[$];
  int         done_q[$];
  logic       outstanding = 1'b0, held = 1'b0, done_bit = 1'b0;
  int         viol = 0, busy_cnt = 0, last_done_t = 0;

  always @(negedge clk) begin
    if (s_rd) begin
      rd_q.push_back(s_addr);
      rd_t.push_back(cyc);
    end
    if (s_rdy) begin
      bit_q.push_back(s_bit);
      rdy_t.push_back(cyc);
      if (outstanding) viol <= viol + 1;
      outstanding <= 1'b1;
      held        <= s_bit;
    end else if (s_bd && s_busy) begin
      outstanding <= 1'b0;
      last_done_t <= cyc;
    end else if (outstanding && s_busy && s_bit !== held) begin
      viol <= viol + 1;
    end
    if (s_fd) begin
      done_q.push_back(cyc);
      done_bit <= s_bit;
    end
    if (s_busy) busy_cnt <= busy_cnt + 1;
    if (!s_busy) outstanding <= 1'b0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete();
    rd_t.delete();
    bit_q.delete();
    rdy_t.delete();
    done_q.delete();
  endtask

  task automatic run_frame(input string tag, input int w32, input int n, input int latch,
                           input int dly, input int poke, input int exp_reads,
                           input int exp_rdy);
    int pb, start, v0, b0, bound, waited, mism_bits, mism_addr, mism_gap, lat_entry, exp_done;
    pb = (w32 != 0) ? 32 : 24;
    @(negedge clk);
    sel = (w32 != 0);
    enc_delay = dly;
    clear_mon();
    v0 = viol;
    b0 = busy_cnt;
    pixel_cnt = 8'(n);
    latch_cnt = 16'(latch);
    frame_start = 1'b1;
    start = cyc;
    waited = 0;
    bound = (n + 1) * pb * (dly + 3) + latch + 50;
    while (done_q.size() == 0 && waited < bound) begin
      @(negedge clk);
      waited++;
      frame_start = (poke != 0 && waited == poke);
      if (frame_start) begin
        pixel_cnt = 8'd9;
        latch_cnt = 16'd100;
      end
    end
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " frame_done seen"}, done_q.size(), 1);
    chk({tag, " idle after frame"}, s_busy, 0);
    chk({tag, " read count"}, rd_q.size(), exp_reads);
    chk({tag, " rdy count"}, bit_q.size(), exp_rdy);
    mism_addr = 0;
    mism_gap = 0;
    for (int k = 0; k < rd_q.size(); k++) begin
      if (rd_q[k] != 8'(k)) mism_addr++;
      if (k * pb >= rdy_t.size() || rdy_t[k * pb] != rd_t[k] + 2) mism_gap++;
    end
    chk({tag, " read addr errors"}, mism_addr, 0);
    chk({tag, " read-to-rdy gap errors"}, mism_gap, 0);
    mism_bits = 0;
    for (int p = 0; p < n; p++) begin
      for (int b = pb - 1; b >= 0; b--) begin
        int idx;
        idx = p * pb + (pb - 1 - b);
        if (idx >= bit_q.size() || bit_q[idx] !== mem[p][b]) mism_bits++;
      end
    end
    chk({tag, " bit stream errors"}, mism_bits, 0);
    lat_entry = (n == 0) ? start + 1 : last_done_t + 1;
    exp_done  = lat_entry + ((latch == 0) ? 1 : latch);
    if (done_q.size() > 0) begin
      chk({tag, " frame_done cycle"}, done_q[0] - start, exp_done - start);
      chk({tag, " busy cycles"}, busy_cnt - b0, done_q[0] - start);
    end
    chk({tag, " bit_data during done"}, done_bit, 0);
    chk({tag, " protocol violations"}, viol - v0, 0);
  endtask

  typedef struct {
    int          w32;
    int          n;
    int          latch;
    int          dly;
    int          poke;
    int          exp_reads;
    int          exp_rdy;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 1, 4, 3, 0, 1, 24, 32'hA50000, 32'h0, 32'h0};
    vecs[1] = '{0, 3, 2, 2, 0, 3, 72, 32'hFFFFFF, 32'h000000, 32'h0F0F0F};
    vecs[2] = '{0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1, 2, 3, 2, 0, 2, 64, 32'hDEADBEEF, 32'h12345678, 32'h0};
    vecs[4] = '{0, 2, 3, 2, 10, 2, 48, 32'h00F00F, 32'h81FF18, 32'h0};
    vecs[5] = '{0, 1, 1, 1, 0, 1, 24, 32'h800001, 32'h0, 32'h0};
    vecs[6] = '{1, 1, 300, 5, 0, 1, 32, 32'h80000001, 32'h0, 32'h0};
    vecs[7] = '{0, 255, 2, 1, 0, 255, 6120, 32'h0, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    chk("reset outputs 24", o24, 0);
    chk("reset outputs 32", o32, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 256; k++) mem[k] = $urandom;
      if (vecs[i].n > 0) begin
        mem[0] = vecs[i].d0;
        mem[1] = vecs[i].d1;
        mem[2] = vecs[i].d2;
      end
      run_frame($sformatf("vec%0d", i), vecs[i].w32, vecs[i].n, vecs[i].latch, vecs[i].dly,
                vecs[i].poke, vecs[i].exp_reads, vecs[i].exp_rdy);
      if (i == 0 && bit_q.size() >= 8) begin
        logic [7:0] first;
        for (int b = 0; b < 8; b++) first[7 - b] = bit_q[b];
        chk("vec0 first byte", first, 8'hA5);
      end
    end

    // Reset wins over a simultaneous frame request.
    @(negedge clk);
    sel = 1'b0;
    rst = 1'b1;
    frame_start = 1'b1;
    pixel_cnt = 8'd5;
    @(negedge clk);
    chk("rst with start outputs", o24, 0);
    rst = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    chk("rst with start stays idle", busy24, 0);

    // Reset in the WAIT of pixel 1 bit 5, with the encoder still owing a done pulse.
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    clear_mon();
    enc_delay = 4;
    pixel_cnt = 8'd3;
    latch_cnt = 16'd5;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int w = 0; w < 2000 && bit_q.size() < 30; w++) @(negedge clk);
    chk("mid-frame rdy reached", bit_q.size(), 30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-frame reset outputs", o24, 0);
    clear_mon();
    repeat (10) @(negedge clk);
    chk("late done rdy count", bit_q.size(), 0);
    chk("late done read count", rd_q.size(), 0);
    chk("no frame_done after abort", done_q.size(), 0);
    chk("idle after abort", busy24, 0);
    run_frame("post-reset", 0, 2, 2, 2, 0, 2, 48);

    for (int r = 0; r < 6; r++) begin
      int w, n, l, d;
      w = $urandom_range(0, 1);
      n = $urandom_range(1, 5);
      l = $urandom_range(0, 12);
      d = $urandom_range(1, 5);
      for (int k = 0; k < 256; k++) mem[k] = $urandom;
      run_frame($sformatf("rnd%0d", r), w, n, l, d, 0, n, n * ((w != 0) ? 32 : 24));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
